arb_tcp_byte_bridge: RTL
========================

// Module: arb_tcp_byte_bridge
// PURPOSE
//  Sink for the 32-bit arbiter output stream (ARB_WRITE_OUT/ARB_DATA_OUT/ARB_READY_OUT).
//  Buffers words in a sync FIFO and serialises them little-endian into the byte-wide TCP TX FIFO.
//  Returns FIFO_FULL / FIFO_NEAR_FULL to the core for TLU veto and throttling.
//  Sits between the core's rrp_arbiter and the SiTCP TX interface, all in BUS_CLK.
// PARAMETERS
//  DEPTH_LOG2    9     word FIFO depth = 2**DEPTH_LOG2 32-bit words
//  NEAR_FULL_TH  448   FIFO_NEAR_FULL asserted when level >= this value (must be < 2**DEPTH_LOG2)
// PORTS
//  BUS_CLK          in   1   single clock for the whole block
//  BUS_RST          in   1   synchronous reset, active-high
//  ENABLE           in   1   1 = serialiser may pop words; 0 = halt at the next word boundary
//  ARB_WRITE_OUT    in   1   word valid from arbiter
//  ARB_DATA_OUT     in   32  word from arbiter
//  ARB_READY_OUT    out  1   word accepted when ARB_WRITE_OUT & ARB_READY_OUT
//  FIFO_FULL        out  1   level == 2**DEPTH_LOG2
//  FIFO_NEAR_FULL   out  1   level >= NEAR_FULL_TH
//  TCP_TX_FULL      in   1   downstream byte FIFO full
//  TCP_TX_WR        out  1   byte strobe
//  TCP_TX_DATA      out  8   byte
//  WORD_CNT         out  32  words fully sent, wraps 0xFFFFFFFF -> 0
//  DROP_CNT         out  16  writes presented while not ready, saturates at 0xFFFF
// BEHAVIOUR
//  Reset: all outputs 0 except ARB_READY_OUT = 1 in the cycle after reset is released.
//   FIFO level is cleared, any partially sent word is discarded, and the state goes to IDLE.
//  ARB_READY_OUT = ~FIFO_FULL. Both are derived from the registered level, never from the same-cycle pop.
//   A pop in the same cycle as full does not open the input until the next cycle.
//  Level update: push and pop in the same cycle leave the level unchanged.
//   Level never exceeds 2**DEPTH_LOG2 and never goes below 0.
//  A write presented while not ready is ignored (the data is not stored) and DROP_CNT is incremented (saturating).
//  Serialiser FSM, two states:
//   IDLE: if ENABLE & level>0, pop the word into SHREG, set BIDX=0, go to SEND.
//   SEND: TCP_TX_DATA = SHREG[8*BIDX+:8] and TCP_TX_WR = ~TCP_TX_FULL (combinational).
//    When TCP_TX_WR is high, BIDX increments.
//    On the BIDX==3 write, WORD_CNT increments. Then, if ENABLE & level>0, the next word is popped
//    in the same cycle and the FSM stays in SEND with BIDX=0. Otherwise it returns to IDLE.
//  Byte order: DATA[7:0], [15:8], [23:16], [31:24].
//  Throughput: 1 byte/cycle sustained with no bubbles between words.
//  Latency: a word accepted in cycle N into an empty FIFO with the FSM in IDLE is popped in N+1.
//   Its first TCP_TX_WR is in N+2 if TCP_TX_FULL is low.
//  TCP_TX_FULL held high: SHREG and BIDX are frozen and no byte is lost or repeated.
//   TCP_TX_WR is low whenever TCP_TX_FULL is high.
//  ENABLE dropped mid-word: the current word completes all 4 bytes, then the FSM goes to IDLE.
//   Words are never split.
//  In IDLE, TCP_TX_WR = 0 and TCP_TX_DATA holds its last value.
// STRUCTURE
//  Sub-module sync_word_fifo: width 32, depth 2**DEPTH_LOG2, registered level output, first-word-fall-through read.
//   Pointers are DEPTH_LOG2 bits and wrap naturally; level is DEPTH_LOG2+1 bits.
//  Shared package/header arb_bridge_defs: FSM encodings (IDLE=0, SEND=1), BYTES_PER_WORD=4, byte-lane index width.
//  Top level holds the FSM, SHREG, BIDX, counters and the flag logic.
// TESTING
//  1. Stream 0x11223344 then 0xAABBCCDD, TCP_TX_FULL=0
//     -> bytes 44,33,22,11,DD,CC,BB,AA on 8 consecutive cycles; first byte 2 cycles after the write; WORD_CNT=2.
//  2. Fill with DEPTH_LOG2=4 and ENABLE=0: 16 writes then a 17th
//     -> FIFO_FULL=1, ARB_READY_OUT=0, DROP_CNT=1, FIFO_NEAR_FULL asserted at level NEAR_FULL_TH.
//  3. TCP_TX_FULL high for 5 cycles while sending after byte 1 of 0xCAFEBABE
//     -> byte stream BE,BA then stall, then FE,CA; no duplicates.
//  4. ENABLE=0 after byte 0 of a word with 3 words queued
//     -> remaining 3 bytes sent, TCP_TX_WR stays low, level stays 2.
//  5. Assert BUS_RST during byte 2 with 5 words queued
//     -> next cycle: level 0, TCP_TX_WR 0, WORD_CNT 0, ARB_READY_OUT 1; a new word is sent from byte 0.
//  6. Random valid/ready/ENABLE over 10k cycles against a scoreboard
//     -> output byte stream equals accepted words in order; DROP_CNT equals refused writes.

Source files
------------

// File: rtl/arb_tcp_byte_bridge_pkg.sv
// Shared definitions for the arbiter-to-TCP byte bridge: serialiser state encoding and
// byte-lane helpers.
package arb_bridge_defs;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BIDX_W         = $clog2(BYTES_PER_WORD);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(BYTES_PER_WORD - 1);

  // Little-endian byte lane select: lane 0 is bits [7:0].
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [BIDX_W-1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/arb_tcp_byte_bridge_sync_word_fifo.sv
// Single-clock 32-bit word FIFO with first-word-fall-through read and a registered
// occupancy level; full/empty are decoded from that registered level only.
module sync_word_fifo #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [31:0]           wr_data,
  input  logic                  rd_en,
  output logic [31:0]           rd_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [31:0]           mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   level_r;
  logic                  push_s;
  logic                  pop_s;

  assign full    = (level_r == FULL_LVL);
  assign empty   = (level_r == {(DEPTH_LOG2+1){1'b0}});
  assign level   = level_r;
  assign push_s  = wr_en & ~full;
  assign pop_s   = rd_en & ~empty;
  assign rd_data = mem_r[rd_ptr_r];

  // Storage array; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers wrap naturally; simultaneous push and pop leave the level unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      level_r  <= {(DEPTH_LOG2+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/arb_tcp_byte_bridge.sv
// Buffers 32-bit arbiter words and serialises them little-endian into the byte-wide
// TCP TX FIFO at one byte per cycle, reporting full/near-full back to the core.
module arb_tcp_byte_bridge
  import arb_bridge_defs::*;
#(
  parameter int DEPTH_LOG2   = 9,
  parameter int NEAR_FULL_TH = 448
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST,
  input  logic        ENABLE,
  input  logic        ARB_WRITE_OUT,
  input  logic [31:0] ARB_DATA_OUT,
  output logic        ARB_READY_OUT,
  output logic        FIFO_FULL,
  output logic        FIFO_NEAR_FULL,
  input  logic        TCP_TX_FULL,
  output logic        TCP_TX_WR,
  output logic [7:0]  TCP_TX_DATA,
  output logic [31:0] WORD_CNT,
  output logic [15:0] DROP_CNT
);

  localparam logic [DEPTH_LOG2:0] NF_TH = NEAR_FULL_TH[DEPTH_LOG2:0];

  logic [31:0]         rd_data_s;
  logic [DEPTH_LOG2:0] level_s;
  logic                full_s;
  logic                empty_s;
  logic                pop_s;
  logic                tx_wr_s;
  logic                last_byte_s;
  state_t              state_r;
  state_t              state_nxt_s;
  logic [31:0]         shreg_r;
  logic [BIDX_W-1:0]   bidx_r;
  logic [31:0]         word_cnt_r;
  logic [15:0]         drop_cnt_r;

  sync_word_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk     (BUS_CLK),
    .rst     (BUS_RST),
    .wr_en   (ARB_WRITE_OUT),
    .wr_data (ARB_DATA_OUT),
    .rd_en   (pop_s),
    .rd_data (rd_data_s),
    .level   (level_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  assign ARB_READY_OUT  = ~full_s;
  assign FIFO_FULL      = full_s;
  assign FIFO_NEAR_FULL = (level_s >= NF_TH);
  assign tx_wr_s        = (state_r == ST_SEND) & ~TCP_TX_FULL;
  assign last_byte_s    = tx_wr_s & (bidx_r == BIDX_LAST);
  assign TCP_TX_WR      = tx_wr_s;
  // In IDLE bidx stays on the last lane sent, so the data output holds its last value.
  assign TCP_TX_DATA    = byte_lane(shreg_r, bidx_r);
  assign WORD_CNT       = word_cnt_r;
  assign DROP_CNT       = drop_cnt_r;

  // Serialiser next state and pop decision; the next word is popped on the final byte for back-to-back words.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ENABLE & ~empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_SEND;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (last_byte_s) begin
          if (ENABLE & ~empty_s) begin
            pop_s       = 1'b1;
            state_nxt_s = ST_SEND;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, shift register, byte index and counters.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_r    <= ST_IDLE;
      shreg_r    <= 32'h0000_0000;
      bidx_r     <= {BIDX_W{1'b0}};
      word_cnt_r <= 32'h0000_0000;
      drop_cnt_r <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;
      if (pop_s) begin
        shreg_r <= rd_data_s;
        bidx_r  <= {BIDX_W{1'b0}};
      end else if (tx_wr_s & ~last_byte_s) begin
        bidx_r  <= bidx_r + {{(BIDX_W-1){1'b0}}, 1'b1};
      end
      if (last_byte_s) word_cnt_r <= word_cnt_r + 32'h0000_0001;
      if (ARB_WRITE_OUT & full_s & (drop_cnt_r != 16'hFFFF)) drop_cnt_r <= drop_cnt_r + 16'h0001;
    end
  end

endmodule
